// File: rtl/wb_commit_unit.sv
// Write-back commit stage: selects the write-back source for each accepted op,
// issues registered register-file write pulses and holds one outstanding load.
module wb_commit_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned LD_TIMEOUT = 255,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       wd_op,
  input  logic [XLEN-1:0]  alu_data,
  input  logic [XLEN-1:0]  u_data,
  input  logic [XLEN-1:0]  link_data,
  input  logic             ld_valid,
  input  logic [XLEN-1:0]  ld_data,
  input  logic             flush,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             pend_valid,
  output logic [4:0]       pend_addr,
  output logic             ld_err,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic {IDLE, WAIT_LD} state_e;

  localparam logic [15:0] TO_LAST = 16'(LD_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [15:0]       to_cnt_q, to_cnt_d;
  logic [4:0]        pend_addr_q, pend_addr_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic              ld_err_q, ld_err_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

  logic [4:0]        op_rd;
  logic [1:0]        op_sel;
  logic              op_work_en;
  logic              accept;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic [XLEN-1:0]   sel_data;

  assign op_rd      = wd_op[7:3];
  assign op_sel     = wd_op[2:1];
  assign op_work_en = wd_op[0];
  assign op_ready   = (state_q == IDLE);
  assign accept     = op_valid & op_ready;

  always_comb begin
    unique case (op_sel)
      2'b10:   sel_data = u_data;
      2'b11:   sel_data = link_data;
      default: sel_data = alu_data;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    pend_addr_d  = pend_addr_q;
    ld_err_d     = ld_err_q;
    wr_en        = 1'b0;
    wr_addr      = op_rd;
    wr_data      = sel_data;
    unique case (state_q)
      IDLE: begin
        if (accept && !flush && op_work_en) begin
          if (op_sel == 2'b01) begin
            if (ld_valid) begin
              wr_en   = 1'b1;
              wr_data = ld_data;
            end else begin
              state_d     = WAIT_LD;
              pend_addr_d = op_rd;
              to_cnt_d    = '0;
            end
          end else begin
            wr_en = 1'b1;
          end
        end
      end
      WAIT_LD: begin
        if (flush) begin
          state_d = IDLE;
        end else if (ld_valid) begin
          wr_en   = 1'b1;
          wr_addr = pend_addr_q;
          wr_data = ld_data;
          state_d = IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          ld_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // x0 writes are suppressed here so address/data keep their last real values
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wr_en && (wr_addr != 5'd0)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wr_addr;
      rf_wdata_d = wr_data;
    end

    retire_cnt_d = retire_cnt_q + CNT_W'(rf_we_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      to_cnt_q     <= '0;
      pend_addr_q  <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      ld_err_q     <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      pend_addr_q  <= pend_addr_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      ld_err_q     <= ld_err_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign pend_valid = (state_q == WAIT_LD);
  assign pend_addr  = pend_addr_q;
  assign ld_err     = ld_err_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit: a default-parameter instance plus a
// short-timeout / narrow-counter instance sharing the same stimulus.
module tb_wb_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [7:0]  wd_op;
  logic [31:0] alu_data, u_data, link_data, ld_data;
  logic        ld_valid;
  logic        flush;

  logic        op_ready, rf_we, pend_valid, ld_err;
  logic [4:0]  rf_waddr, pend_addr;
  logic [31:0] rf_wdata, retire_cnt;

  logic        to_op_ready, to_rf_we, to_pend_valid, to_ld_err;
  logic [4:0]  to_rf_waddr, to_pend_addr;
  logic [31:0] to_rf_wdata;
  logic [1:0]  to_retire_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_commit_unit #(.XLEN(32), .LD_TIMEOUT(255), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .wd_op(wd_op),
    .alu_data(alu_data), .u_data(u_data), .link_data(link_data),
    .ld_valid(ld_valid), .ld_data(ld_data), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_valid(pend_valid), .pend_addr(pend_addr), .ld_err(ld_err),
    .retire_cnt(retire_cnt)
  );

  wb_commit_unit #(.XLEN(32), .LD_TIMEOUT(4), .CNT_W(2)) dut_to (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(to_op_ready), .wd_op(wd_op),
    .alu_data(alu_data), .u_data(u_data), .link_data(link_data),
    .ld_valid(ld_valid), .ld_data(ld_data), .flush(flush),
    .rf_we(to_rf_we), .rf_waddr(to_rf_waddr), .rf_wdata(to_rf_wdata),
    .pend_valid(to_pend_valid), .pend_addr(to_pend_addr), .ld_err(to_ld_err),
    .retire_cnt(to_retire_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    op_valid = 1'b0; wd_op = 8'h00; ld_valid = 1'b0; flush = 1'b0;
    alu_data = 32'h0; u_data = 32'h0; link_data = 32'h0; ld_data = 32'h0;
  endtask

  task automatic set_op(input logic [4:0] rd, input logic [1:0] sel, input logic we);
    op_valid = 1'b1;
    wd_op    = {rd, sel, we};
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0h exp=0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin failures++; $display("FAIL reset_waddr got=%0h exp=0", rf_waddr); end
    checks++; if (rf_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%0h exp=0", rf_wdata); end
    checks++; if (pend_valid !== 1'b0 || pend_addr !== 5'd0) begin failures++; $display("FAIL reset_pend got=%0h/%0h exp=0/0", pend_valid, pend_addr); end
    checks++; if (ld_err !== 1'b0 || retire_cnt !== 32'd0) begin failures++; $display("FAIL reset_err_cnt got=%0h/%0h exp=0/0", ld_err, retire_cnt); end
    checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0h exp=1", op_ready); end
  endtask

  task automatic test_alu();
    do_reset();
    set_op(5'd3, 2'b00, 1'b1); alu_data = 32'h1234;
    tick();
    op_valid = 1'b0;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h1234}) begin failures++; $display("FAIL alu_write got=%0h/%0h/%0h exp=1/3/1234", rf_we, rf_waddr, rf_wdata); end
    alu_data = 32'h5555;
    tick();
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd3, 32'h1234}) begin failures++; $display("FAIL alu_hold got=%0h/%0h/%0h exp=0/3/1234", rf_we, rf_waddr, rf_wdata); end
    checks++; if (retire_cnt !== 32'd1) begin failures++; $display("FAIL alu_cnt got=%0d exp=1", retire_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_op(5'd5, 2'b10, 1'b1); u_data = 32'hA000; alu_data = 32'h1111;
    tick();
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hA000}) begin failures++; $display("FAIL b2b_first got=%0h/%0h/%0h exp=1/5/a000", rf_we, rf_waddr, rf_wdata); end
    set_op(5'd1, 2'b11, 1'b1); link_data = 32'h104;
    tick();
    op_valid = 1'b0;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 32'h104}) begin failures++; $display("FAIL b2b_second got=%0h/%0h/%0h exp=1/1/104", rf_we, rf_waddr, rf_wdata); end
    tick();
    checks++; if (rf_we !== 1'b0 || retire_cnt !== 32'd2) begin failures++; $display("FAIL b2b_cnt got=%0h/%0d exp=0/2", rf_we, retire_cnt); end
  endtask

  task automatic test_load_wait();
    do_reset();
    set_op(5'd7, 2'b01, 1'b1);
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({pend_valid, pend_addr, op_ready, rf_we} !== {1'b1, 5'd7, 1'b0, 1'b0}) begin failures++; $display("FAIL ld_pending[%0d] got=%0h/%0h/%0h/%0h exp=1/7/0/0", i, pend_valid, pend_addr, op_ready, rf_we); end
      if (i == 3) begin ld_valid = 1'b1; ld_data = 32'hDEAD; end
      tick();
    end
    ld_valid = 1'b0;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'hDEAD}) begin failures++; $display("FAIL ld_write got=%0h/%0h/%0h exp=1/7/dead", rf_we, rf_waddr, rf_wdata); end
    checks++; if (op_ready !== 1'b1 || pend_valid !== 1'b0) begin failures++; $display("FAIL ld_ready got=%0h/%0h exp=1/0", op_ready, pend_valid); end
  endtask

  task automatic test_rd0_and_nowork();
    do_reset();
    set_op(5'd0, 2'b01, 1'b1); ld_valid = 1'b1; ld_data = 32'hBEEF;
    tick();
    checks++; if (rf_we !== 1'b0 || op_ready !== 1'b1) begin failures++; $display("FAIL rd0_ld_same got=%0h/%0h exp=0/1", rf_we, op_ready); end
    set_op(5'd4, 2'b00, 1'b0); ld_valid = 1'b0; alu_data = 32'h77;
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL nowork_we got=%0h exp=0", rf_we); end
    set_op(5'd0, 2'b01, 1'b1);
    tick();
    op_valid = 1'b0;
    checks++; if (pend_valid !== 1'b1 || pend_addr !== 5'd0) begin failures++; $display("FAIL rd0_wait got=%0h/%0h exp=1/0", pend_valid, pend_addr); end
    ld_valid = 1'b1; ld_data = 32'hCAFE;
    tick();
    ld_valid = 1'b0;
    checks++; if (rf_we !== 1'b0 || op_ready !== 1'b1) begin failures++; $display("FAIL rd0_consume got=%0h/%0h exp=0/1", rf_we, op_ready); end
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    tick();
    checks++; if ({rf_we, rf_waddr, rf_wdata, retire_cnt} !== {1'b0, 5'd0, 32'h0, 32'd0}) begin failures++; $display("FAIL rd0_quiet got=%0h/%0h/%0h/%0d exp=0/0/0/0", rf_we, rf_waddr, rf_wdata, retire_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    set_op(5'd9, 2'b01, 1'b1);
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (to_pend_valid !== 1'b1 || to_ld_err !== 1'b0) begin failures++; $display("FAIL to_wait[%0d] got=%0h/%0h exp=1/0", i, to_pend_valid, to_ld_err); end
      tick();
    end
    checks++; if ({to_ld_err, to_op_ready, to_rf_we} !== 3'b110) begin failures++; $display("FAIL to_expire got=%0h/%0h/%0h exp=1/1/0", to_ld_err, to_op_ready, to_rf_we); end
    checks++; if (ld_err !== 1'b0 || pend_valid !== 1'b1) begin failures++; $display("FAIL to_long_still got=%0h/%0h exp=0/1", ld_err, pend_valid); end
    ld_valid = 1'b1; ld_data = 32'h99;
    tick();
    ld_valid = 1'b0;
    checks++; if (to_rf_we !== 1'b0 || to_ld_err !== 1'b1) begin failures++; $display("FAIL to_late_ld got=%0h/%0h exp=0/1", to_rf_we, to_ld_err); end
  endtask

  task automatic test_flush();
    do_reset();
    set_op(5'd6, 2'b01, 1'b1);
    tick();
    op_valid = 1'b0;
    flush = 1'b1; ld_valid = 1'b1; ld_data = 32'h4444;
    tick();
    flush = 1'b0; ld_valid = 1'b0;
    checks++; if ({rf_we, op_ready, pend_valid, ld_err} !== 4'b0100) begin failures++; $display("FAIL flush_wait got=%0h/%0h/%0h/%0h exp=0/1/0/0", rf_we, op_ready, pend_valid, ld_err); end
    set_op(5'd2, 2'b00, 1'b1); alu_data = 32'h22; flush = 1'b1;
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL flush_accept got=%0h exp=0", rf_we); end
    flush = 1'b0;
    tick();
    op_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (retire_cnt !== 32'd1 || rf_waddr !== 5'd2) begin failures++; $display("FAIL flush_keep_write got=%0d/%0h exp=1/2", retire_cnt, rf_waddr); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    set_op(5'd12, 2'b00, 1'b1); alu_data = 32'h600D;
    tick();
    set_op(5'd11, 2'b01, 1'b1);
    tick();
    op_valid = 1'b0;
    tick();
    checks++; if (pend_valid !== 1'b1 || pend_addr !== 5'd11) begin failures++; $display("FAIL rstmid_pre got=%0h/%0h exp=1/b", pend_valid, pend_addr); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({rf_we, rf_waddr, rf_wdata, pend_valid, pend_addr, ld_err, retire_cnt, op_ready} !== {1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1}) begin
      failures++; $display("FAIL rstmid_async got=%0h/%0h/%0h/%0h/%0h/%0h/%0d/%0h exp=0/0/0/0/0/0/0/1", rf_we, rf_waddr, rf_wdata, pend_valid, pend_addr, ld_err, retire_cnt, op_ready);
    end
    ld_valid = 1'b1; ld_data = 32'h1;
    tick();
    rst = 1'b0; ld_valid = 1'b0;
    tick();
    checks++; if (rf_we !== 1'b0 || retire_cnt !== 32'd0) begin failures++; $display("FAIL rstmid_after got=%0h/%0d exp=0/0", rf_we, retire_cnt); end
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      set_op(5'(i), 2'b00, 1'b1); alu_data = 32'(i);
      tick();
    end
    op_valid = 1'b0;
    checks++; if (to_retire_cnt !== 2'd3 || to_rf_we !== 1'b1) begin failures++; $display("FAIL wrap_pre got=%0d/%0h exp=3/1", to_retire_cnt, to_rf_we); end
    tick();
    checks++; if (to_retire_cnt !== 2'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", to_retire_cnt); end
    checks++; if (retire_cnt !== 32'd4) begin failures++; $display("FAIL wrap_wide got=%0d exp=4", retire_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_alu();
    test_back_to_back();
    test_load_wait();
    test_rd0_and_nowork();
    test_timeout();
    test_flush();
    test_reset_mid_wait();
    test_cnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
